// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [4:0]  LAST_ITER = 5'd31;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    // Multiply leaves the low product in lo and the high product in hi;
    // divide leaves the quotient in lo and the remainder in hi.
    function automatic logic [31:0] select_result(
        input op_e         op,
        input logic [31:0] hi,
        input logic [31:0] lo
    );
        case (op)
            OP_MUL, OP_DIVU:  select_result = lo;
            OP_MULHU, OP_REMU: select_result = hi;
            default:          select_result = lo;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_sequencer_32b_if.sv
// Launch/completion handshake between the execute stage and the multiply/divide unit.
interface muldiv_sequencer_32b_if;
    import muldiv_pkg::*;

    logic              start;
    op_e               op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic              busy;
    logic              done;
    logic [XLEN-1:0]   result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );

endinterface

// File: rtl/kogge_stone_adder_subtractor_32b.sv
// 32-bit Kogge-Stone parallel-prefix adder; s=1 turns it into a - b (cout=1 means no borrow).
module kogge_stone_adder_subtractor_32b (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] bx_s;
    logic [31:0] g_s;
    logic [31:0] p_s;
    logic [31:0] gg_s;
    logic [31:0] pp_s;
    logic [31:0] gn_s;
    logic [31:0] pn_s;

    // Generate/propagate prefix tree; carry-in folded into bit 0 generate.
    always_comb begin
        bx_s     = b ^ {32{s}};
        g_s      = a & bx_s;
        p_s      = a ^ bx_s;
        gg_s     = g_s;
        gg_s[0]  = g_s[0] | (p_s[0] & s);
        pp_s     = p_s;
        gn_s     = gg_s;
        pn_s     = pp_s;
        for (int stride = 32'sd1; stride < 32'sd32; stride = stride * 32'sd2) begin
            gn_s = gg_s;
            pn_s = pp_s;
            for (int i = 32'sd0; i < 32'sd32; i++) begin
                if (i >= stride) begin
                    gn_s[i] = gg_s[i] | (pp_s[i] & gg_s[i - stride]);
                    pn_s[i] = pp_s[i] & pp_s[i - stride];
                end else begin
                    gn_s[i] = gg_s[i];
                    pn_s[i] = pp_s[i];
                end
            end
            gg_s = gn_s;
            pp_s = pn_s;
        end
        sum  = p_s ^ {gg_s[30:0], s};
        cout = gg_s[31];
    end

endmodule

// File: rtl/muldiv_sequencer_32b.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer around one shared adder.
// Define MULDIV_DIV_EN to compile in the divide datapath (ops DIVU/REMU).
module muldiv_sequencer_32b #(
    parameter int XLEN  = muldiv_pkg::XLEN,
    parameter int CNT_W = muldiv_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    muldiv_sequencer_32b_if.slave  bus
);
    import muldiv_pkg::*;

    state_e             state_r;
    op_e                op_r;
    logic [XLEN-1:0]    hi_r;
    logic [XLEN-1:0]    lo_r;
    logic [XLEN-1:0]    opnd_r;
    logic [XLEN-1:0]    result_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;

    logic [XLEN-1:0]    add_a_s;
    logic [XLEN-1:0]    add_b_s;
    logic [XLEN-1:0]    add_sum_s;
    logic               add_sub_s;
    logic               add_cout_s;
    logic [XLEN-1:0]    trial_s;
    logic               quot_bit_s;
    logic               is_div_s;
    logic [XLEN-1:0]    next_hi_s;
    logic [XLEN-1:0]    next_lo_s;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

    kogge_stone_adder_subtractor_32b u_adder (
        .a    (add_a_s),
        .b    (add_b_s),
        .s    (add_sub_s),
        .cout (add_cout_s),
        .sum  (add_sum_s)
    );

    // Adder operand steering and next hi/lo for one shift-add or restore-subtract step.
    always_comb begin
        trial_s  = {hi_r[XLEN-2:0], lo_r[XLEN-1]};
`ifdef MULDIV_DIV_EN
        is_div_s = op_r[1];
`else
        is_div_s = 1'b0;
`endif
        add_sub_s = is_div_s;
        if (is_div_s) begin
            add_a_s = trial_s;
            add_b_s = opnd_r;
        end else begin
            add_a_s = hi_r;
            add_b_s = lo_r[0] ? opnd_r : {XLEN{1'b0}};
        end
        // hi[31] set means the 33-bit trial remainder already exceeds any divisor.
        quot_bit_s = add_cout_s | hi_r[XLEN-1];
        if (is_div_s) begin
            next_hi_s = quot_bit_s ? add_sum_s : trial_s;
            next_lo_s = {lo_r[XLEN-2:0], quot_bit_s};
        end else begin
            next_hi_s = {add_cout_s, add_sum_s[XLEN-1:1]};
            next_lo_s = {add_sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_MUL;
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            opnd_r   <= {XLEN{1'b0}};
            result_r <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_r   <= bus.op;
                        opnd_r <= bus.b;
                        lo_r   <= bus.a;
                        hi_r   <= {XLEN{1'b0}};
                        cnt_r  <= {CNT_W{1'b0}};
                        busy_r <= 1'b1;
`ifdef MULDIV_DIV_EN
                        if (bus.op[1] && (bus.b == {XLEN{1'b0}})) begin
                            state_r  <= ST_FIN;
                            done_r   <= 1'b1;
                            hi_r     <= bus.a;
                            lo_r     <= DIV0_QUOT;
                            result_r <= (bus.op == OP_REMU) ? bus.a : DIV0_QUOT;
                        end else begin
                            state_r <= ST_RUN;
                        end
`else
                        if (bus.op[1]) begin
                            state_r  <= ST_FIN;
                            done_r   <= 1'b1;
                            result_r <= {XLEN{1'b0}};
                        end else begin
                            state_r <= ST_RUN;
                        end
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    hi_r <= next_hi_s;
                    lo_r <= next_lo_s;
                    // Result is taken from the final step's next values so done lands with FIN.
                    if (cnt_r == LAST_ITER) begin
                        state_r  <= ST_FIN;
                        done_r   <= 1'b1;
                        result_r <= select_result(op_r, next_hi_s, next_lo_s);
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer_32b.sv
// Directed self-checking bench for muldiv_sequencer_32b; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_sequencer_32b;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    muldiv_sequencer_32b_if bus ();

    muldiv_sequencer_32b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Present a start pulse for exactly one sampling edge; returns in cycle 1.
    task automatic launch(input op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Launch, wait (bounded) for done, capture result and cycle, then step to the next cycle.
    task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int cyc);
        launch(op, a, b);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        res = bus.result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", bus.result); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        launch(OP_MUL, 32'd7, 32'd6);
        for (int c = 1; c <= 34; c++) begin
            checks++;
            if (bus.busy !== (c <= 33)) begin
                errors++; $display("FAIL mul_busy cycle %0d got %b want %b", c, bus.busy, (c <= 33));
            end
            checks++;
            if (bus.done !== (c == 33)) begin
                errors++; $display("FAIL mul_done cycle %0d got %b want %b", c, bus.done, (c == 33));
            end
            if (c >= 33) begin
                checks++;
                if (bus.result !== 32'h0000_002A) begin
                    errors++; $display("FAIL mul_result cycle %0d got %h want 0000002a", c, bus.result);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mulhu();
        logic [31:0] res;
        int          cyc;
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL mulhu_cycle got %0d want 33", cyc); end
        checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_result got %h want fffffffe", res); end
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL mul_ff_cycle got %0d want 33", cyc); end
        checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL mul_ff_result got %h want 00000001", res); end
    endtask

    task automatic test_div();
        logic [31:0] res;
        int          cyc;
        int          exp_cyc;
        exp_cyc = DIV_ON ? 33 : 1;
        run_op(OP_DIVU, 32'd100, 32'd7, res, cyc);
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL divu_cycle got %0d want %0d", cyc, exp_cyc); end
        checks++; if (res !== (DIV_ON ? 32'd14 : 32'd0)) begin errors++; $display("FAIL divu_result got %h want %h", res, (DIV_ON ? 32'd14 : 32'd0)); end
        run_op(OP_REMU, 32'd100, 32'd7, res, cyc);
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL remu_cycle got %0d want %0d", cyc, exp_cyc); end
        checks++; if (res !== (DIV_ON ? 32'd2 : 32'd0)) begin errors++; $display("FAIL remu_result got %h want %h", res, (DIV_ON ? 32'd2 : 32'd0)); end
        run_op(OP_DIVU, 32'h8000_0000, 32'd1, res, cyc);
        checks++; if (res !== (DIV_ON ? 32'h8000_0000 : 32'd0)) begin errors++; $display("FAIL divu_msb_result got %h want %h", res, (DIV_ON ? 32'h8000_0000 : 32'd0)); end
    endtask

    task automatic test_div_zero();
        logic [31:0] res;
        int          cyc;
        run_op(OP_DIVU, 32'd5, 32'd0, res, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL div0_cycle got %0d want 1", cyc); end
        checks++; if (res !== (DIV_ON ? DIV0_QUOT : 32'd0)) begin errors++; $display("FAIL div0_quot got %h want %h", res, (DIV_ON ? DIV0_QUOT : 32'd0)); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL div0_busy_cycle2 got %b want 0", bus.busy); end
        run_op(OP_REMU, 32'd5, 32'd0, res, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL rem0_cycle got %0d want 1", cyc); end
        checks++; if (res !== (DIV_ON ? 32'd5 : 32'd0)) begin errors++; $display("FAIL rem0_result got %h want %h", res, (DIV_ON ? 32'd5 : 32'd0)); end
    endtask

    task automatic test_ignore_start();
        int cyc;
        launch(OP_MUL, 32'd3, 32'd5);
        repeat (9) begin @(posedge clk); #1; end
        bus.op    = OP_MULHU;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 11;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== 33) begin errors++; $display("FAIL ignore_cycle got %0d want 33", cyc); end
        checks++; if (bus.result !== 32'h0000_000F) begin errors++; $display("FAIL ignore_result got %h want 0000000f", bus.result); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          cyc;
        launch(OP_MUL, 32'd2, 32'd3);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (bus.result !== 32'd6) begin errors++; $display("FAIL b2b_first got %h want 00000006", bus.result); end
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fin_start_busy got %b want 0", bus.busy); end
        run_op(OP_MUL, 32'd4, 32'd4, res, cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_cycle got %0d want 33", cyc); end
        checks++; if (res !== 32'd16) begin errors++; $display("FAIL b2b_result got %h want 00000010", res); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] res;
        int          cyc;
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (11) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got %h want 00000000", bus.result); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(OP_MUL, 32'd2, 32'd2, res, cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL post_rst_cycle got %0d want 33", cyc); end
        checks++; if (res !== 32'd4) begin errors++; $display("FAIL post_rst_result got %h want 00000004", res); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        test_reset();
        test_mul();
        test_mulhu();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
